// File: rtl/sram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// sram_fifo_ctrl
//   Synchronous FIFO controller wrapped around a 32x32 two-port SRAM that is
//   physically a single-port macro. At most one SRAM access happens per cycle,
//   and reads take priority over writes. A 2-entry output buffer hides the
//   SRAM's 1-cycle read latency from the consumer.
//
// Ports
//   clk        : single clock (also drives the SRAM RCLK/WCLK)
//   rst        : synchronous active-high reset
//   clr        : synchronous flush, same effect on state as rst
//   s_valid/s_ready/s_data : write stream (valid/ready)
//   m_valid/m_ready/m_data : read stream (valid/ready), m_data from a register
//   level      : words held = SRAM + in-flight read + output buffer (0..34)
//   ram_rceb/ram_raddr/ram_rdata : SRAM read port (enable active low)
//   ram_wceb/ram_waddr/ram_wdata : SRAM write port (enable active low)
// ----------------------------------------------------------------------------
module sram_fifo_ctrl #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [5:0]    level,
    output logic          ram_rceb,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_wceb,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Registered state
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   ram_cnt_r;
    logic          rd_inflight_r;
    logic [1:0]    out_cnt_r;
    logic [DW-1:0] obuf0_r;      // head of output buffer
    logic [DW-1:0] obuf1_r;      // second entry of output buffer
    logic [5:0]    level_r;

    // Combinational decisions and next-state values
    logic          out_room_s;
    logic          rd_issue_s;
    logic          s_ready_s;
    logic          wr_acc_s;
    logic          cap_s;
    logic          pop_s;
    logic [AW:0]   ram_cnt_nxt_s;
    logic          rd_inflight_nxt_s;
    logic [1:0]    out_cnt_nxt_s;
    logic [DW-1:0] obuf0_nxt_s;
    logic [DW-1:0] obuf1_nxt_s;
    logic [5:0]    level_nxt_s;

    // Output-buffer slots still free once the in-flight word lands.
    assign out_room_s = ({1'b0, out_cnt_r} + {2'b00, rd_inflight_r}) < 3'd2;

    // Access arbitration from registered state only; a pending read blocks writes.
    always_comb begin
        rd_issue_s = 1'b0;
        s_ready_s  = 1'b0;
        if (!rst && !clr) begin
            rd_issue_s = (ram_cnt_r != {(AW+1){1'b0}}) && out_room_s;
            s_ready_s  = (ram_cnt_r < DEPTH_C) && !rd_issue_s;
        end else begin
            rd_issue_s = 1'b0;
            s_ready_s  = 1'b0;
        end
    end

    assign wr_acc_s = s_valid && s_ready_s;
    assign cap_s    = rd_inflight_r;            // ram_rdata is only meaningful here
    assign pop_s    = (out_cnt_r != 2'd0) && m_ready;

    // SRAM counter and in-flight flag; issue and accept are mutually exclusive.
    always_comb begin
        ram_cnt_nxt_s     = ram_cnt_r + (AW+1)'(wr_acc_s) - (AW+1)'(rd_issue_s);
        rd_inflight_nxt_s = rd_issue_s;
    end

    // Output buffer update: capture appends at the tail, pop shifts the head out.
    always_comb begin
        obuf0_nxt_s   = obuf0_r;
        obuf1_nxt_s   = obuf1_r;
        out_cnt_nxt_s = out_cnt_r;
        case ({cap_s, pop_s})
            2'b10: begin
                if (out_cnt_r == 2'd0) begin
                    obuf0_nxt_s = ram_rdata;
                end else begin
                    obuf1_nxt_s = ram_rdata;
                end
                out_cnt_nxt_s = out_cnt_r + 2'd1;
            end
            2'b01: begin
                obuf0_nxt_s   = obuf1_r;
                out_cnt_nxt_s = out_cnt_r - 2'd1;
            end
            2'b11: begin
                // Count unchanged; the captured word goes behind whatever remains.
                if (out_cnt_r == 2'd1) begin
                    obuf0_nxt_s = ram_rdata;
                end else begin
                    obuf0_nxt_s = obuf1_r;
                    obuf1_nxt_s = ram_rdata;
                end
            end
            default: begin
                obuf0_nxt_s   = obuf0_r;
                obuf1_nxt_s   = obuf1_r;
                out_cnt_nxt_s = out_cnt_r;
            end
        endcase
    end

    // Level is registered from next-state values so it tracks every edge.
    always_comb begin
        level_nxt_s = 6'(ram_cnt_nxt_s) + 6'(rd_inflight_nxt_s) + 6'(out_cnt_nxt_s);
    end

    // State register; rst and clr both return everything to empty.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            ram_cnt_r     <= {(AW+1){1'b0}};
            rd_inflight_r <= 1'b0;
            out_cnt_r     <= 2'd0;
            obuf0_r       <= {DW{1'b0}};
            obuf1_r       <= {DW{1'b0}};
            level_r       <= 6'd0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_issue_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            ram_cnt_r     <= ram_cnt_nxt_s;
            rd_inflight_r <= rd_inflight_nxt_s;
            out_cnt_r     <= out_cnt_nxt_s;
            obuf0_r       <= obuf0_nxt_s;
            obuf1_r       <= obuf1_nxt_s;
            level_r       <= level_nxt_s;
        end
    end

    assign s_ready   = s_ready_s;
    assign m_valid   = (out_cnt_r != 2'd0);
    assign m_data    = obuf0_r;
    assign level     = level_r;
    assign ram_rceb  = !rd_issue_s;
    assign ram_raddr = rd_ptr_r;
    assign ram_wceb  = !wr_acc_s;
    assign ram_waddr = wr_ptr_r;
    assign ram_wdata = s_data;

endmodule
